// File: rtl/data_line_memory_if.sv
// Request/response bundle between the data cache (master) and the line memory (slave).
interface data_line_memory_if;
  logic         mem_enable_i;
  logic         mem_write_i;
  logic [31:0]  mem_addr_i;
  logic [255:0] mem_data_i;
  logic [255:0] mem_data_o;
  logic         mem_ack_o;

  modport master (output mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
                  input  mem_data_o, mem_ack_o);
  modport slave  (input  mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
                  output mem_data_o, mem_ack_o);
endinterface

// File: rtl/data_line_memory.sv
// Fixed-latency 256-bit line memory: one outstanding request, access performed on the
// edge that enters ACK, single-cycle registered ack.
module data_line_memory #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic               clk_i,
  input  logic               rst_i,
  data_line_memory_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t          state, state_nxt;
  logic [7:0]      cnt;
  logic            wr_q;
  logic [AW-1:0]   idx_q;
  logic [255:0]    dat_q;
  logic [255:0]    rd_q;
  logic            ack_q;
  logic            access;
  logic [255:0]    mem [DEPTH];

  // Upper address bits alias and the byte offset is ignored.
  logic unused_addr;
  assign unused_addr = ^{bus.mem_addr_i[31:5+AW], bus.mem_addr_i[4:0]};

  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      IDLE: if (bus.mem_enable_i) state_nxt = BUSY;
      BUSY: if (cnt == 8'd0) begin
        state_nxt = ACK;
        access    = 1'b1;
      end
      ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      wr_q  <= 1'b0;
      idx_q <= '0;
      dat_q <= '0;
      rd_q  <= '0;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= (state_nxt == ACK);
      if (state == IDLE && bus.mem_enable_i) begin
        wr_q  <= bus.mem_write_i;
        idx_q <= bus.mem_addr_i[5 +: AW];
        dat_q <= bus.mem_data_i;
        cnt   <= 8'(LATENCY - 1);
      end else if (state == BUSY && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (access && !wr_q) rd_q <= mem[idx_q];
    end
  end

  // Array is deliberately outside the reset domain; reset only cancels the pending access.
  always_ff @(posedge clk_i) begin
    if (access && wr_q) mem[idx_q] <= dat_q;
  end

  assign bus.mem_data_o = rd_q;
  assign bus.mem_ack_o  = ack_q;
endmodule

// File: tb/tb_data_line_memory.sv
// Scoreboard bench: each accepted request pushes its expected ack edge and mem_data_o;
// a negedge monitor pops and compares on every ack.
module tb_data_line_memory;
  localparam int LAT   = 10;
  localparam int DEPTH = 512;
  localparam int AW    = $clog2(DEPTH);

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  data_line_memory_if bus();
  data_line_memory #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [255:0] data;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [255:0] model [int];
  logic [255:0] cur_rd = '0;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lidx(input logic [31:0] a);
    return int'(a[5 +: AW]);
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Writes leave mem_data_o at the last read value; reads return the model line.
  task automatic push(input bit wr, input logic [31:0] a, input logic [255:0] d, input int acc);
    exp_t e;
    e.cyc = acc + LAT;
    if (wr) begin
      model[lidx(a)] = d;
      e.data = cur_rd;
    end else begin
      e.data = model[lidx(a)];
      cur_rd = e.data;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (bus.mem_ack_o === 1'b1) begin
      if (sb.size() == 0) chk("unexp_ack", bus.mem_ack_o, 1'b0);
      else begin
        mon_e = sb.pop_front();
        chk("ack_cyc", cyc, mon_e.cyc);
        chk("ack_data", bus.mem_data_o, mon_e.data);
      end
    end
  end

  task automatic drive(input bit wr, input logic [31:0] a, input logic [255:0] d);
    bus.mem_enable_i = 1'b1;
    bus.mem_write_i  = wr;
    bus.mem_addr_i   = a;
    bus.mem_data_i   = d;
  endtask

  task automatic wait_ack(output int c);
    c = -1;
    for (int n = 0; n < LAT + 6; n++) begin
      @(negedge clk_i);
      if (bus.mem_ack_o === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("ack_timeout", bus.mem_ack_o, 1'b1);
  endtask

  // Enable held until the ack cycle has passed, then dropped.
  task automatic xact(input bit wr, input logic [31:0] a, input logic [255:0] d);
    int c;
    @(posedge clk_i); #1;
    drive(wr, a, d);
    push(wr, a, d, cyc + 1);
    wait_ack(c);
    @(posedge clk_i); #1;
    bus.mem_enable_i = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] p, q, pat;
    logic [31:0]  lines [4];
    int c1, c2;

    bus.mem_enable_i = 1'b0;
    bus.mem_write_i  = 1'b0;
    bus.mem_addr_i   = '0;
    bus.mem_data_i   = '0;

    repeat (3) @(negedge clk_i);
    chk("rst_ack", bus.mem_ack_o, 1'b0);
    chk("rst_data", bus.mem_data_o, '0);
    rst_i = 1'b1;

    // Write then read back the same line.
    pat = {8{32'hDEADBEEF}};
    xact(1'b1, 32'h0000_0040, pat);
    xact(1'b0, 32'h0000_0040, rnd256());
    chk("rd_deadbeef", bus.mem_data_o, pat);

    // Writeback held straight into refill of a different line.
    q = {8{32'h2222_2222}};
    xact(1'b1, 32'h0000_0800, q);
    @(posedge clk_i); #1;
    drive(1'b1, 32'h0000_0400, {8{32'h1111_1111}});
    push(1'b1, 32'h0000_0400, {8{32'h1111_1111}}, cyc + 1);
    wait_ack(c1);
    bus.mem_write_i = 1'b0;
    bus.mem_addr_i  = 32'h0000_0800;
    bus.mem_data_i  = rnd256();
    // ACK cycle ignores enable; the refill is taken one IDLE edge later.
    push(1'b0, 32'h0000_0800, '0, c1 + 2);
    wait_ack(c2);
    // From the edge ending the first ack to the edge raising the second.
    chk("b2b_gap", c2 - (c1 + 1), LAT + 1);
    chk("b2b_data", bus.mem_data_o, q);
    @(posedge clk_i); #1;
    bus.mem_enable_i = 1'b0;

    // Address change and enable drop mid-flight must not disturb the read.
    p = rnd256();
    xact(1'b1, 32'h0000_0020, p);
    xact(1'b1, 32'h0000_0060, rnd256());
    @(posedge clk_i); #1;
    drive(1'b0, 32'h0000_0020, '0);
    push(1'b0, 32'h0000_0020, '0, cyc + 1);
    repeat (4) @(posedge clk_i); #1;
    bus.mem_addr_i   = 32'h0000_0060;
    bus.mem_enable_i = 1'b0;
    wait_ack(c1);
    chk("drop_en_data", bus.mem_data_o, p);
    @(posedge clk_i); #1;

    // Reset in the middle of a write discards it.
    p = rnd256();
    xact(1'b1, 32'h0000_0100, p);
    @(posedge clk_i); #1;
    drive(1'b1, 32'h0000_0100, ~p);
    repeat (6) @(posedge clk_i); #1;
    rst_i = 1'b0;
    bus.mem_enable_i = 1'b0;
    #1;
    chk("midrst_ack", bus.mem_ack_o, 1'b0);
    chk("midrst_data", bus.mem_data_o, '0);
    sb.delete();
    cur_rd = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      chk("no_ack_after_rst", bus.mem_ack_o, 1'b0);
    end
    xact(1'b0, 32'h0000_0100, '0);
    chk("abort_kept_old", bus.mem_data_o, p);

    // Address aliasing above the index field.
    pat = {8{32'hA5A5_A5A5}};
    xact(1'b1, 32'h0000_4000, pat);
    xact(1'b0, 32'h0000_0000, '0);
    chk("alias", bus.mem_data_o, pat);

    // mem_data_o holds through a later write.
    xact(1'b0, 32'h0000_0040, '0);
    pat = bus.mem_data_o;
    xact(1'b1, 32'h0000_0060, rnd256());
    repeat (3) begin
      @(negedge clk_i);
      chk("hold_after_wr", bus.mem_data_o, cur_rd);
    end

    // Random mix over a handful of lines.
    for (int i = 0; i < 4; i++) begin
      lines[i] = 32'h0000_1000 + 32'(i) * 32'h20;
      xact(1'b1, lines[i], rnd256());
    end
    for (int i = 0; i < 12; i++) begin
      xact(1'($urandom_range(0, 1)), lines[$urandom_range(0, 3)], rnd256());
    end

    repeat (3) @(negedge clk_i);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
